// File: rtl/timestamp_delta.sv
// ---------------------------------------------------------------------------
// timestamp_delta
//
// Pairs one timestamp from each of two latch channels and reports their
// difference (ts2 - ts1). Each channel has a latched 64-bit timestamp and a
// "latched" flag that is asynchronous to iCLK. The block waits for both
// captures, computes the delta and shows it to a consumer until it is
// acknowledged. It then asks the upstream latches to release, and counts the
// accepted pairs. A capture whose partner never arrives inside pTIMEOUT
// cycles is dropped with a one-cycle oTimeout pulse.
//
// Parameters
//   pWIDTH    timestamp width; presented as two 32-bit words (64)
//   pTIMEOUT  cycles allowed between the two channel captures
//   pSYNC     depth of the ready synchronizers (>= 2)
//
// Ports
//   iCLK, iRST                 clock, synchronous active-high reset
//   i1COUNTER / i1COUNTERHi    channel-1 latched timestamp, low/high word
//   iRdy1                      channel-1 latched flag (asynchronous)
//   i2COUNTER / i2COUNTERHi    channel-2 latched timestamp, low/high word
//   iRdy2                      channel-2 latched flag (asynchronous)
//   iAck                       consumer accepts the presented result
//   oResetLatch1/2             release request to each upstream latch
//   oDELTA / oDELTAHi          ts2 - ts1, low/high word
//   oFirst                     0 = ch1 first or same cycle, 1 = ch2 first
//   oValid                     result valid
//   oTimeout                   one-cycle pulse on an unmatched capture
//   oPAIRS                     count of accepted pairs (wraps)
// ---------------------------------------------------------------------------
module timestamp_delta #(
    parameter int pWIDTH   = 64,
    parameter int pTIMEOUT = 1024,
    parameter int pSYNC    = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] i1COUNTER,
    input  logic [31:0] i1COUNTERHi,
    input  logic        iRdy1,
    input  logic [31:0] i2COUNTER,
    input  logic [31:0] i2COUNTERHi,
    input  logic        iRdy2,
    input  logic        iAck,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    output logic [31:0] oDELTA,
    output logic [31:0] oDELTAHi,
    output logic        oFirst,
    output logic        oValid,
    output logic        oTimeout,
    output logic [15:0] oPAIRS
);

    localparam int TW = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(pTIMEOUT - 1);
    localparam int SW = $clog2(pSYNC + 1) + 1;
    localparam logic [SW-1:0] START_LAST = SW'(pSYNC);

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        WAIT2,
        WAIT1,
        CALC,
        PRESENT,
        RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [pSYNC-1:0]  sync1_q, sync2_q;
    logic              prev1_q, prev2_q;
    logic              r1, r2, rise1, rise2;
    logic [pWIDTH-1:0] ts1_q, ts2_q, delta_q;
    logic [TW-1:0]     tmoCnt_q;
    logic [SW-1:0]     startCnt_q;
    logic [15:0]       pairCnt_q;
    logic              firstPend_q, first_q, timeout_q;

    logic cap1, cap2, firstSet, firstVal, tmoClr, tmoFire, pairInc;

    // The synchronized flag is the last stage of each synchronizer. A rise
    // is a synchronized high that was low one cycle earlier.
    assign r1    = sync1_q[pSYNC-1];
    assign r2    = sync2_q[pSYNC-1];
    assign rise1 = r1 & ~prev1_q;
    assign rise2 = r2 & ~prev2_q;

    // Synchronizers and the previous-level flops run every cycle, STARTUP
    // included. STARTUP is long enough that after it ends a latch held
    // across reset looks stale (high, no rise) instead of like a new capture.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev1_q <= 1'b0;
            prev2_q <= 1'b0;
        end else begin
            sync1_q <= {sync1_q[pSYNC-2:0], iRdy1};
            sync2_q <= {sync2_q[pSYNC-2:0], iRdy2};
            prev1_q <= r1;
            prev2_q <= r2;
        end
    end

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= STARTUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle datapath strobes. Captures are only
    // allowed in IDLE and in the WAIT state for the missing channel, so
    // rises in any other state are ignored. The timeout check sits behind
    // the partner check, so a partner on the last allowed cycle still pairs.
    always_comb begin
        state_d  = state_q;
        cap1     = 1'b0;
        cap2     = 1'b0;
        firstSet = 1'b0;
        firstVal = 1'b0;
        tmoClr   = 1'b0;
        tmoFire  = 1'b0;
        pairInc  = 1'b0;
        case (state_q)
            STARTUP: begin
                if (startCnt_q == START_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cap1 = rise1;
                cap2 = rise2;
                if (rise1 && rise2) begin
                    state_d  = CALC;
                    firstSet = 1'b1;
                    firstVal = 1'b0;
                end else if (rise1) begin
                    state_d  = WAIT2;
                    firstSet = 1'b1;
                    firstVal = 1'b0;
                    tmoClr   = 1'b1;
                end else if (rise2) begin
                    state_d  = WAIT1;
                    firstSet = 1'b1;
                    firstVal = 1'b1;
                    tmoClr   = 1'b1;
                end else if (r1 || r2) begin
                    state_d = RELEASE;
                end
            end
            WAIT2: begin
                cap2 = rise2;
                if (rise2) begin
                    state_d = CALC;
                end else if (tmoCnt_q == TMO_LAST) begin
                    state_d = RELEASE;
                    tmoFire = 1'b1;
                end
            end
            WAIT1: begin
                cap1 = rise1;
                if (rise1) begin
                    state_d = CALC;
                end else if (tmoCnt_q == TMO_LAST) begin
                    state_d = RELEASE;
                    tmoFire = 1'b1;
                end
            end
            CALC: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                if (iAck) begin
                    state_d = RELEASE;
                    pairInc = 1'b1;
                end
            end
            RELEASE: begin
                if (!r1 && !r2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = STARTUP;
            end
        endcase
    end

    // Datapath registers. oFirst is first kept as a pending flag and copied
    // to the output together with the delta in CALC. That way every
    // presented output changes only on entry to PRESENT and otherwise holds.
    // The subtraction is modulo 2^pWIDTH, so an upstream counter wrap
    // between the two captures still gives the small positive delta.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ts1_q       <= '0;
            ts2_q       <= '0;
            delta_q     <= '0;
            tmoCnt_q    <= '0;
            startCnt_q  <= '0;
            pairCnt_q   <= '0;
            firstPend_q <= 1'b0;
            first_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (cap1) begin
                ts1_q <= {i1COUNTERHi, i1COUNTER};
            end
            if (cap2) begin
                ts2_q <= {i2COUNTERHi, i2COUNTER};
            end
            if (firstSet) begin
                firstPend_q <= firstVal;
            end
            if (state_q == STARTUP) begin
                startCnt_q <= startCnt_q + SW'(1);
            end
            if (tmoClr) begin
                tmoCnt_q <= '0;
            end else if (state_q == WAIT1 || state_q == WAIT2) begin
                tmoCnt_q <= tmoCnt_q + TW'(1);
            end
            if (state_q == CALC) begin
                delta_q <= ts2_q - ts1_q;
                first_q <= firstPend_q;
            end
            if (pairInc) begin
                pairCnt_q <= pairCnt_q + 16'd1;
            end
            timeout_q <= tmoFire;
        end
    end

    assign oValid       = (state_q == PRESENT);
    assign oResetLatch1 = (state_q == RELEASE) & r1;
    assign oResetLatch2 = (state_q == RELEASE) & r2;
    assign oDELTA       = delta_q[31:0];
    assign oDELTAHi     = delta_q[63:32];
    assign oFirst       = first_q;
    assign oTimeout     = timeout_q;
    assign oPAIRS       = pairCnt_q;

endmodule

// File: tb/tb_timestamp_delta.sv
// ---------------------------------------------------------------------------
// tb_timestamp_delta
//
// Directed bench for timestamp_delta, built with pTIMEOUT = 16. Inputs are
// driven and outputs sampled 1 ns after each rising edge. With pSYNC = 2, a
// flag driven just after an edge shows as a rise two edges later. It is
// captured on the third edge and oValid is high after the fourth.
// ---------------------------------------------------------------------------
module tb_timestamp_delta;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [31:0] i1COUNTER, i1COUNTERHi, i2COUNTER, i2COUNTERHi;
    logic        iRdy1, iRdy2, iAck;
    logic        oResetLatch1, oResetLatch2, oFirst, oValid, oTimeout;
    logic [31:0] oDELTA, oDELTAHi;
    logic [15:0] oPAIRS;

    int checkCnt = 0;
    int passCnt = 0;
    int validCycles = 0;
    int timeoutCycles = 0;
    int validMark;

    timestamp_delta #(
        .pWIDTH  (64),
        .pTIMEOUT(16),
        .pSYNC   (2)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .i1COUNTER   (i1COUNTER),
        .i1COUNTERHi (i1COUNTERHi),
        .iRdy1       (iRdy1),
        .i2COUNTER   (i2COUNTER),
        .i2COUNTERHi (i2COUNTERHi),
        .iRdy2       (iRdy2),
        .iAck        (iAck),
        .oResetLatch1(oResetLatch1),
        .oResetLatch2(oResetLatch2),
        .oDELTA      (oDELTA),
        .oDELTAHi    (oDELTAHi),
        .oFirst      (oFirst),
        .oValid      (oValid),
        .oTimeout    (oTimeout),
        .oPAIRS      (oPAIRS)
    );

    // 10 ns clock.
    always #5 iCLK = ~iCLK;

    // Count the cycles in which oValid and oTimeout are high. The timeout
    // test uses these counts to check the pulse width and that no result
    // was presented.
    always @(negedge iCLK) begin
        if (oValid) validCycles = validCycles + 1;
        if (oTimeout) timeoutCycles = timeoutCycles + 1;
    end

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [63:0] ts);
        if (ch == 1) begin
            i1COUNTER   = ts[31:0];
            i1COUNTERHi = ts[63:32];
            iRdy1       = 1'b1;
        end else begin
            i2COUNTER   = ts[31:0];
            i2COUNTERHi = ts[63:32];
            iRdy2       = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt = checkCnt + 1;
        assert (obs === exp) passCnt = passCnt + 1;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Acknowledge the presented result, expect both latches to be released
    // and the pair count to reach expPairs. Then drop both flags and expect
    // the release requests to go away.
    task automatic ackAndRelease(input string tag, input logic [15:0] expPairs);
        iAck = 1'b1;
        stepCycles(1);
        iAck = 1'b0;
        checkOutput({tag, "_validAfterAck"}, oValid, 1'b0);
        checkOutput({tag, "_pairs"}, oPAIRS, expPairs);
        checkOutput({tag, "_latch1"}, oResetLatch1, 1'b1);
        checkOutput({tag, "_latch2"}, oResetLatch2, 1'b1);
        iRdy1 = 1'b0;
        iRdy2 = 1'b0;
        stepCycles(5);
        checkOutput({tag, "_latchesClear"}, {oResetLatch1, oResetLatch2}, 2'b00);
    endtask

    initial begin
        iRST = 1'b1;
        iAck = 1'b0;
        iRdy1 = 1'b0;
        iRdy2 = 1'b0;
        i1COUNTER = '0;
        i1COUNTERHi = '0;
        i2COUNTER = '0;
        i2COUNTERHi = '0;
        stepCycles(3);

        // Reset state
        checkOutput("rst_valid", oValid, 1'b0);
        checkOutput("rst_delta", {oDELTAHi, oDELTA}, 64'h0);
        checkOutput("rst_first", oFirst, 1'b0);
        checkOutput("rst_timeout", oTimeout, 1'b0);
        checkOutput("rst_latches", {oResetLatch1, oResetLatch2}, 2'b00);
        checkOutput("rst_pairs", oPAIRS, 16'd0);
        iRST = 1'b0;
        stepCycles(6);

        // ch1 first, ch2 ten cycles later: delta 0x64
        applyStimulus(1, 64'h0000_0000_0000_0100);
        stepCycles(10);
        applyStimulus(2, 64'h0000_0000_0000_0164);
        stepCycles(3);
        checkOutput("a_validEarly", oValid, 1'b0);
        stepCycles(1);
        checkOutput("a_valid", oValid, 1'b1);
        checkOutput("a_delta", {oDELTAHi, oDELTA}, 64'h64);
        checkOutput("a_first", oFirst, 1'b0);
        stepCycles(2);
        checkOutput("a_validHeld", oValid, 1'b1);
        checkOutput("a_deltaHeld", {oDELTAHi, oDELTA}, 64'h64);
        ackAndRelease("a", 16'd1);

        // ch2 first: negative delta, oFirst = 1
        applyStimulus(2, 64'h10);
        stepCycles(5);
        applyStimulus(1, 64'h30);
        stepCycles(3);
        checkOutput("b_validEarly", oValid, 1'b0);
        stepCycles(1);
        checkOutput("b_valid", oValid, 1'b1);
        checkOutput("b_delta", {oDELTAHi, oDELTA}, 64'hFFFF_FFFF_FFFF_FFE0);
        checkOutput("b_first", oFirst, 1'b1);
        ackAndRelease("b", 16'd2);

        // Upstream counter wrap between captures
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFF0);
        stepCycles(4);
        applyStimulus(2, 64'h10);
        stepCycles(4);
        checkOutput("c_valid", oValid, 1'b1);
        checkOutput("c_delta", {oDELTAHi, oDELTA}, 64'h20);
        checkOutput("c_first", oFirst, 1'b0);
        ackAndRelease("c", 16'd3);

        // Both flags rise in the same cycle
        applyStimulus(1, 64'h1000);
        applyStimulus(2, 64'h1005);
        stepCycles(3);
        checkOutput("d_validEarly", oValid, 1'b0);
        stepCycles(1);
        checkOutput("d_valid", oValid, 1'b1);
        checkOutput("d_delta", {oDELTAHi, oDELTA}, 64'h5);
        checkOutput("d_first", oFirst, 1'b0);
        ackAndRelease("d", 16'd4);

        // Timeout: only ch1 arrives; a late ch2 is released, not paired
        validMark = validCycles;
        applyStimulus(1, 64'h500);
        stepCycles(18);
        checkOutput("e_timeoutEarly", oTimeout, 1'b0);
        stepCycles(1);
        checkOutput("e_timeout", oTimeout, 1'b1);
        checkOutput("e_latch1", oResetLatch1, 1'b1);
        applyStimulus(2, 64'h600);
        stepCycles(1);
        checkOutput("e_timeoutPulse", oTimeout, 1'b0);
        stepCycles(1);
        checkOutput("e_latch2", oResetLatch2, 1'b1);
        iRdy1 = 1'b0;
        iRdy2 = 1'b0;
        stepCycles(6);
        checkOutput("e_latchesClear", {oResetLatch1, oResetLatch2}, 2'b00);
        checkOutput("e_noValid", validCycles - validMark, 0);
        checkOutput("e_timeoutWidth", timeoutCycles, 1);
        checkOutput("e_pairs", oPAIRS, 16'd4);
        checkOutput("e_deltaHeld", {oDELTAHi, oDELTA}, 64'h5);

        // Reset while presenting with iAck high; iRdy1 held across reset
        applyStimulus(1, 64'h7);
        applyStimulus(2, 64'h9);
        stepCycles(4);
        checkOutput("f_valid", oValid, 1'b1);
        iAck = 1'b1;
        iRST = 1'b1;
        stepCycles(1);
        checkOutput("f_validDropped", oValid, 1'b0);
        checkOutput("f_pairs", oPAIRS, 16'd0);
        checkOutput("f_delta", {oDELTAHi, oDELTA}, 64'h0);
        iAck = 1'b0;
        iRdy2 = 1'b0;
        stepCycles(1);
        iRST = 1'b0;
        stepCycles(5);
        checkOutput("f_staleLatch1", oResetLatch1, 1'b1);
        checkOutput("f_noValid", oValid, 1'b0);
        iRdy1 = 1'b0;
        stepCycles(5);
        checkOutput("f_latchClear", oResetLatch1, 1'b0);
        applyStimulus(1, 64'h200);
        stepCycles(3);
        applyStimulus(2, 64'h250);
        stepCycles(4);
        checkOutput("f_nextValid", oValid, 1'b1);
        checkOutput("f_nextDelta", {oDELTAHi, oDELTA}, 64'h50);
        checkOutput("f_nextFirst", oFirst, 1'b0);
        ackAndRelease("f", 16'd1);

        $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/timestamp_delta.md
TIMESTAMP_DELTA -- requirements
Module: timestamp_delta

Interface
REQ-001 Parameter pWIDTH, 64, timestamp width in bits (presented as two 32-bit words).
REQ-002 Parameter pTIMEOUT, 1024, maximum cycles allowed between the two channel captures.
REQ-003 Parameter pSYNC, 2, ready-synchronizer depth; SHALL be >= 2.
REQ-004 iCLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 iRST  input  1  synchronous, active-high reset.
REQ-006 i1COUNTER / i1COUNTERHi  input  32 each  channel-1 latched timestamp, low/high word.
REQ-007 iRdy1  input  1  channel-1 latched flag from the counter stage; asynchronous to iCLK.
REQ-008 i2COUNTER / i2COUNTERHi / iRdy2  input  32/32/1  channel-2 equivalents.
REQ-009 oResetLatch1 / oResetLatch2  output  1  release request to the upstream latch channel.
REQ-010 oDELTA / oDELTAHi  output  32 each  result (ts2 - ts1), low/high word.
REQ-011 oFirst  output  1  0 = ch1 first or same cycle; 1 = ch2 first.
REQ-012 oValid  output  1  result valid; iAck  input  1  consumer accepts result.
REQ-013 oTimeout  output  1  one-cycle pulse on an unmatched capture.
REQ-014 oPAIRS  output  16  count of accepted pairs.

Function
REQ-015 iRdy1/iRdy2 SHALL each pass a pSYNC-flop synchronizer; the FSM uses only the synchronized levels r1/r2 and rises (rN & ~prevN).
REQ-016 On rise1 in IDLE or WAIT1, the block SHALL register {i1COUNTERHi,i1COUNTER} into ts1 that cycle; ch2 likewise into ts2 in IDLE or WAIT2; rises in other states SHALL be ignored.
REQ-017 The FSM SHALL have states STARTUP, IDLE, WAIT2 (ts1 held), WAIT1 (ts2 held), CALC, PRESENT, RELEASE.
REQ-018 IDLE transitions: rise1 & rise2 -> CALC with oFirst=0; rise1 only -> WAIT2 with oFirst=0; rise2 only -> WAIT1 with oFirst=1.
REQ-019 IDLE with r1 or r2 high and no rise (stale latch) -> RELEASE.
REQ-020 WAIT2 on rise2 -> CALC; WAIT1 on rise1 -> CALC.
REQ-021 The timeout counter SHALL clear on WAITx entry and increment every WAITx cycle.
REQ-022 Counter == pTIMEOUT-1 with no partner -> oTimeout high for exactly 1 cycle, go to RELEASE; no oValid; oPAIRS unchanged.
REQ-023 CALC SHALL last 1 cycle: delta <= ts2 - ts1 modulo 2^pWIDTH (two's complement), so an upstream counter wrap yields the correct small delta; then -> PRESENT.
REQ-024 PRESENT: oValid=1; oDELTA, oDELTAHi and oFirst stable until oValid & iAck; then -> RELEASE with oPAIRS+1, wrapping 0xFFFF -> 0.
REQ-025 Latency from the second capturing rise to oValid high SHALL be 2 iCLK cycles.
REQ-026 RELEASE: oResetLatchN = rN for each channel; exit to IDLE when r1=r2=0, so a late partner after timeout is also released.
REQ-027 oValid SHALL be low outside PRESENT; oDELTA/oDELTAHi/oFirst hold their last values outside PRESENT.

Reset
REQ-028 iRST SHALL have priority over every other event and produce: state STARTUP; ts1, ts2, delta, synchronizer and prev flops, timeout counter = 0; oDELTA=0, oDELTAHi=0, oFirst=0, oValid=0, oTimeout=0, oResetLatch1=0, oResetLatch2=0, oPAIRS=0.
REQ-029 STARTUP SHALL last pSYNC+1 cycles with rise detection masked, then -> IDLE, where REQ-019 clears any latch held across reset.
REQ-030 iRST asserted during PRESENT with iAck=1 SHALL drop oValid and SHALL NOT increment oPAIRS.

Verification
REQ-031 ts1=0x0000_0000_0000_0100, then ts2=0x0000_0000_0000_0164 after 10 cycles -> oValid 2 cycles after rise2; oDELTA=0x64, oDELTAHi=0, oFirst=0; on iAck, oResetLatch1/2 high until rdy low; oPAIRS=1.
REQ-032 ch2 first, ts2=0x10, ts1=0x30 -> oDELTA=0xFFFF_FFE0, oDELTAHi=0xFFFF_FFFF, oFirst=1.
REQ-033 Wrap: ts1=0xFFFF_FFFF_FFFF_FFF0, ts2=0x0000_0000_0000_0010 -> oDELTA=0x20, oDELTAHi=0.
REQ-034 iRdy1 and iRdy2 rise in the same cycle -> WAITx skipped, oFirst=0, oValid at the same 2-cycle latency.
REQ-035 pTIMEOUT=16, only iRdy1 -> oTimeout pulse 16 cycles after capture, oResetLatch1 high, oValid never high, oPAIRS unchanged; a later iRdy2 is released, not paired.
REQ-036 iRST during PRESENT with iAck=1 -> oValid=0, oPAIRS=0; iRdy1 held high across reset is released after STARTUP; the next pair computes correctly.
